// File: rtl/chip8_fetch.sv
// CHIP-8 instruction fetch stage: owns the program counter and reads two
// big-endian opcode bytes from byte-wide program RAM on request.
module chip8_fetch #(
    parameter int                 ADDR_W   = 12,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'('h200)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_start,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_value,
    input  logic              pc_skip,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_data,
    output logic [15:0]       opcode,
    output logic              opcode_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_HI    = 2'd1,
        RD_LO    = 2'd2,
        LATCH_LO = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       opcode_q, opcode_d;
    logic [7:0]        hi_q, hi_d;
    logic              valid_q, valid_d;

    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] pc_plus2;

    assign pc_plus1 = pc_q + ADDR_W'(1);
    assign pc_plus2 = pc_q + ADDR_W'(2);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            opcode_q <= 16'h0000;
            hi_q     <= 8'h00;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            opcode_q <= opcode_d;
            hi_q     <= hi_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        opcode_d = opcode_q;
        hi_d     = hi_q;
        valid_d  = 1'b0;
        mem_rd   = 1'b0;
        mem_addr = '0;

        unique case (state_q)
            IDLE: begin
                // One request per cycle; lower-priority ones are dropped.
                if (pc_load) begin
                    pc_d = pc_load_value;
                end else if (pc_skip) begin
                    pc_d = pc_plus2;
                end else if (fetch_start) begin
                    state_d = RD_HI;
                end
            end
            RD_HI: begin
                mem_rd   = 1'b1;
                mem_addr = pc_q;
                state_d  = RD_LO;
            end
            RD_LO: begin
                mem_rd   = 1'b1;
                mem_addr = pc_plus1;
                // Hi byte is staged so opcode never shows a half-updated value.
                hi_d     = mem_data;
                state_d  = LATCH_LO;
            end
            LATCH_LO: begin
                opcode_d = {hi_q, mem_data};
                pc_d     = pc_plus2;
                valid_d  = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign opcode       = opcode_q;
    assign opcode_valid = valid_q;
    assign pc           = pc_q;
    assign busy         = (state_q != IDLE);

endmodule
